// File: rtl/env_dump_reader.sv
// env_dump_reader: walks the environment grid in raster order over the lookup port and streams one record per cell.
// Build option ENV_DUMP_SKIP_EMPTY_EN: cells with sugar=0 and signal=0 produce no record.

module env_dump_reader #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int SIGNAL_bits = 4,
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 120,
    parameter int LOOKUP_LAT  = 1,
    parameter int CNT_bits    = 15
) (
    input  logic                                 clk,
    input  logic                                 RESET_SIM,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic [X_bits-1:0]                    lookup_X,
    output logic [Y_bits-1:0]                    lookup_Y,
    input  logic                                 lookup_sugar,
    input  logic [SIGNAL_bits-1:0]               lookup_signal,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [X_bits+Y_bits+SIGNAL_bits:0]   out_data,
    output logic                                 out_last,
    output logic [CNT_bits-1:0]                  sugar_total,
    output logic [SIGNAL_bits-1:0]               signal_max
);

    localparam int REC_bits = X_bits + Y_bits + 1 + SIGNAL_bits;
    localparam int LAT_bits = 3;
    localparam logic [LAT_bits-1:0] LAT_LOAD = LAT_bits'(LOOKUP_LAT - 1);
    localparam logic [X_bits-1:0]   X_LAST   = X_bits'(X_MAX - 1);
    localparam logic [Y_bits-1:0]   Y_LAST   = Y_bits'(Y_MAX - 1);
    localparam logic [CNT_bits-1:0] CNT_SAT  = {CNT_bits{1'b1}};

    // state | meaning
    // IDLE  | waiting for start; last pass totals held
    // WAIT  | address stable, lat down-counter running until lookup data is valid
    // EMIT  | record presented, waiting for out_ready
    // DONE  | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [X_bits-1:0]      x_q, x_d, x_adv;
    logic [Y_bits-1:0]      y_q, y_d, y_adv;
    logic [LAT_bits-1:0]    lat_q, lat_d;
    logic [REC_bits-1:0]    data_q, data_d;
    logic                   last_q, last_d;
    logic [CNT_bits-1:0]    cnt_q, cnt_d;
    logic [SIGNAL_bits-1:0] max_q, max_d;
    logic                   last_cell;
    logic                   skip_cell;

    assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        if (x_q == X_LAST) begin
            x_adv = '0;
            y_adv = y_q + 1'b1;
        end else begin
            x_adv = x_q + 1'b1;
            y_adv = y_q;
        end
    end

`ifdef ENV_DUMP_SKIP_EMPTY_EN
    assign skip_cell = !lookup_sugar && (lookup_signal == '0);
`else
    assign skip_cell = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lat_d   = lat_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    x_d     = '0;
                    y_d     = '0;
                    lat_d   = LAT_LOAD;
                    cnt_d   = '0;
                    max_d   = '0;
                end
            end
            WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    if (lookup_sugar && (cnt_q != CNT_SAT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (lookup_signal > max_q) begin
                        max_d = lookup_signal;
                    end
                    // Skipped cells still count toward the totals above.
                    if (skip_cell) begin
                        if (last_cell) begin
                            state_d = DONE;
                        end else begin
                            x_d   = x_adv;
                            y_d   = y_adv;
                            lat_d = LAT_LOAD;
                        end
                    end else begin
                        data_d  = {x_q, y_q, lookup_sugar, lookup_signal};
                        last_d  = last_cell;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    last_d = 1'b0;
                    if (last_cell) begin
                        state_d = DONE;
                    end else begin
                        x_d     = x_adv;
                        y_d     = y_adv;
                        lat_d   = LAT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET_SIM) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign out_valid   = (state_q == EMIT);
    assign out_data    = data_q;
    assign out_last    = last_q;
    assign lookup_X    = x_q;
    assign lookup_Y    = y_q;
    assign sugar_total = cnt_q;
    assign signal_max  = max_q;

endmodule

// File: tb/tb_env_dump_reader.sv
// Scoreboard bench for env_dump_reader: instance A is a 4x3 grid at latency 1, instance B an 8x2 grid at latency 3.
// Expected records are queued when a pass is launched and checked by a separate monitor on every handshake.

module tb_env_dump_reader;

    localparam int DW    = 20;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
`ifdef ENV_DUMP_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;

    logic          a_rst, a_start, a_busy, a_done, a_sug, a_valid, a_ready, a_last;
    logic [7:0]    a_lx;
    logic [6:0]    a_ly;
    logic [3:0]    a_sig, a_max;
    logic [DW-1:0] a_data;
    logic [14:0]   a_tot;

    logic          b_rst, b_start, b_busy, b_done, b_sug, b_valid, b_ready, b_last;
    logic [7:0]    b_lx;
    logic [6:0]    b_ly;
    logic [3:0]    b_sig, b_max;
    logic [DW-1:0] b_data;
    logic [14:0]   b_tot;

    int n_vec = 0;
    int n_err = 0;
    int grid_mode_a = 0;
    logic [DW:0] qa[$];
    logic [DW:0] qb[$];

    env_dump_reader #(.X_MAX(4), .Y_MAX(3), .LOOKUP_LAT(LAT_A)) dut_a (
        .clk(clk), .RESET_SIM(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
        .lookup_X(a_lx), .lookup_Y(a_ly), .lookup_sugar(a_sug), .lookup_signal(a_sig),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_last(a_last),
        .sugar_total(a_tot), .signal_max(a_max)
    );

    env_dump_reader #(.X_MAX(8), .Y_MAX(2), .LOOKUP_LAT(LAT_B)) dut_b (
        .clk(clk), .RESET_SIM(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
        .lookup_X(b_lx), .lookup_Y(b_ly), .lookup_sugar(b_sug), .lookup_signal(b_sig),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_last(b_last),
        .sugar_total(b_tot), .signal_max(b_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Grid contents as {sugar, signal}; mode 0: signal=x+y, mode 1: signal 7 only at (2,1).
    function automatic logic [4:0] cell_val(input int x, input int y, input int mode);
        logic       s;
        logic [3:0] g;
        s = ((x == 1) && (y == 0)) || ((x == 3) && (y == 2));
        if (mode == 0) g = 4'(x + y);
        else           g = ((x == 2) && (y == 1)) ? 4'd7 : 4'd0;
        return {s, g};
    endfunction

    function automatic bit emitted(input logic [4:0] v);
        return (v != 5'd0) || !SKIP;
    endfunction

    function automatic int exp_cyc(input int xm, input int ym, input int lat, input int mode);
        int c;
        c = 2;
        for (int y = 0; y < ym; y++)
            for (int x = 0; x < xm; x++)
                c += emitted(cell_val(x, y, mode)) ? lat + 1 : lat;
        return c;
    endfunction

    task automatic push_pass(input bit to_b, input int xm, input int ym, input int mode, input int ncells);
        logic [4:0]  v;
        logic [DW:0] e;
        for (int y = 0; y < ym; y++) begin
            for (int x = 0; x < xm; x++) begin
                v = cell_val(x, y, mode);
                if ((y * xm + x) < ncells && emitted(v)) begin
                    e = {((x == xm - 1) && (y == ym - 1)), 8'(x), 7'(y), v};
                    if (to_b) qb.push_back(e);
                    else      qa.push_back(e);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Environment models: data becomes correct only once the address has been stable LAT cycles.
    initial begin
        logic [7:0] px;
        logic [6:0] py;
        int         age;
        logic [4:0] v;
        px = '0; py = '0; age = 0;
        a_sug = 1'b0; a_sig = '0;
        forever begin
            @(negedge clk);
            if (a_lx != px || a_ly != py) begin
                age = 1; px = a_lx; py = a_ly;
            end else if (age < 100) age++;
            v = cell_val(int'(a_lx), int'(a_ly), grid_mode_a);
            if (age >= LAT_A) {a_sug, a_sig} = v;
            else              {a_sug, a_sig} = ~v;
        end
    end

    initial begin
        logic [7:0] px;
        logic [6:0] py;
        int         age;
        logic [4:0] v;
        px = '0; py = '0; age = 0;
        b_sug = 1'b0; b_sig = '0;
        forever begin
            @(negedge clk);
            if (b_lx != px || b_ly != py) begin
                age = 1; px = b_lx; py = b_ly;
            end else if (age < 100) age++;
            v = cell_val(int'(b_lx), int'(b_ly), 0);
            if (age >= LAT_B) {b_sug, b_sig} = v;
            else              {b_sug, b_sig} = ~v;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks records hold still while stalled.
    initial begin
        logic          a_held, b_held;
        logic [DW-1:0] a_hold, b_hold;
        logic [DW:0]   e;
        a_held = 1'b0; b_held = 1'b0; a_hold = '0; b_hold = '0;
        forever begin
            @(negedge clk);
            if (a_held) begin
                chk("A stall valid", 32'(a_valid), 32'd1);
                chk("A stall data", 32'(a_data), 32'(a_hold));
            end
            a_held = a_valid && !a_ready && !a_rst;
            a_hold = a_data;
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL A unexpected record: got 0x%0h, expected none", {a_last, a_data});
                end else begin
                    e = qa.pop_front();
                    chk("A record", 32'({a_last, a_data}), 32'(e));
                end
            end
            if (b_held) begin
                chk("B stall valid", 32'(b_valid), 32'd1);
                chk("B stall data", 32'(b_data), 32'(b_hold));
            end
            b_held = b_valid && !b_ready && !b_rst;
            b_hold = b_data;
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL B unexpected record: got 0x%0h, expected none", {b_last, b_data});
                end else begin
                    e = qb.pop_front();
                    chk("B record", 32'({b_last, b_data}), 32'(e));
                end
            end
        end
    end

    task automatic start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int rmode, input int pulse_at, input int hold_from, output int cyc);
        cyc = 2;
        while (!a_done && cyc < 3000) begin
            a_ready = (rmode == 0) || (cyc % 4 == 0);
            a_start = (cyc == pulse_at) || (hold_from > 0 && cyc >= hold_from);
            step();
            cyc++;
        end
        if (!a_done) begin
            n_vec++; n_err++;
            $display("FAIL A done timeout: got no done after %0d cycles, expected done", cyc);
        end
    endtask

    task automatic wait_done_b(output int cyc);
        cyc = 2;
        while (!b_done && cyc < 3000) begin
            b_ready = 1'b1;
            step();
            cyc++;
        end
        if (!b_done) begin
            n_vec++; n_err++;
            $display("FAIL B done timeout: got no done after %0d cycles, expected done", cyc);
        end
    endtask

    initial begin
        int cyc;
        bit found;
        a_rst = 1'b1; b_rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        repeat (3) step();
        a_rst = 1'b0; b_rst = 1'b0;
        step();

        chk("A reset busy", 32'(a_busy), 32'd0);
        chk("A reset done", 32'(a_done), 32'd0);
        chk("A reset valid", 32'(a_valid), 32'd0);
        chk("A reset last", 32'(a_last), 32'd0);
        chk("A reset data", 32'(a_data), 32'd0);
        chk("A reset lookup_X", 32'(a_lx), 32'd0);
        chk("A reset lookup_Y", 32'(a_ly), 32'd0);
        chk("A reset sugar_total", 32'(a_tot), 32'd0);
        chk("A reset signal_max", 32'(a_max), 32'd0);

        // Pass 1: grid mode 0, ready tied high.
        grid_mode_a = 0;
        push_pass(1'b0, 4, 3, 0, 12);
        start_a();
        chk("A busy after start", 32'(a_busy), 32'd1);
        wait_done_a(0, -1, 0, cyc);
        chk("A done cycle", 32'(cyc), 32'(exp_cyc(4, 3, LAT_A, 0)));
        chk("A sugar_total", 32'(a_tot), 32'd2);
        chk("A signal_max", 32'(a_max), 32'd5);
        chk("A queue drained", 32'(qa.size()), 32'd0);
        step();
        chk("A done one cycle", 32'(a_done), 32'd0);
        chk("A idle busy", 32'(a_busy), 32'd0);

        // Pass 2: grid mode 1; totals from pass 1 must be cleared.
        grid_mode_a = 1;
        push_pass(1'b0, 4, 3, 1, 12);
        start_a();
        chk("A cleared sugar_total", 32'(a_tot), 32'd0);
        chk("A cleared signal_max", 32'(a_max), 32'd0);
        wait_done_a(0, -1, 0, cyc);
        chk("A mode1 done cycle", 32'(cyc), 32'(exp_cyc(4, 3, LAT_A, 1)));
        chk("A mode1 sugar_total", 32'(a_tot), 32'd2);
        chk("A mode1 signal_max", 32'(a_max), 32'd7);
        chk("A mode1 queue drained", 32'(qa.size()), 32'd0);
        step();

        // Pass 3: grid mode 0 with ready 1 on / 3 off.
        grid_mode_a = 0;
        push_pass(1'b0, 4, 3, 0, 12);
        start_a();
        wait_done_a(1, -1, 0, cyc);
        chk("A stall sugar_total", 32'(a_tot), 32'd2);
        chk("A stall signal_max", 32'(a_max), 32'd5);
        chk("A stall queue drained", 32'(qa.size()), 32'd0);
        step();
        a_ready = 1'b1;

        // Pass 4: start pulsed while busy, then held high through DONE to relaunch.
        push_pass(1'b0, 4, 3, 0, 12);
        push_pass(1'b0, 4, 3, 0, 12);
        start_a();
        wait_done_a(0, 10, 20, cyc);
        chk("A ignored start done cycle", 32'(cyc), 32'(exp_cyc(4, 3, LAT_A, 0)));
        step();
        chk("A idle between passes", 32'(a_busy), 32'd0);
        step();
        a_start = 1'b0;
        chk("A relaunch busy", 32'(a_busy), 32'd1);
        chk("A relaunch sugar_total", 32'(a_tot), 32'd0);
        chk("A relaunch signal_max", 32'(a_max), 32'd0);
        wait_done_a(0, -1, 0, cyc);
        chk("A relaunch done cycle", 32'(cyc), 32'(exp_cyc(4, 3, LAT_A, 0)));
        chk("A relaunch sugar_total end", 32'(a_tot), 32'd2);
        chk("A relaunch queue drained", 32'(qa.size()), 32'd0);

        // Instance B: latency 3 with garbage data until the third cycle.
        push_pass(1'b1, 8, 2, 0, 16);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        wait_done_b(cyc);
        chk("B done cycle", 32'(cyc), 32'(exp_cyc(8, 2, LAT_B, 0)));
        chk("B sugar_total", 32'(b_tot), 32'd1);
        chk("B signal_max", 32'(b_max), 32'd8);
        chk("B queue drained", 32'(qb.size()), 32'd0);
        step();

        // Instance B: reset while cell (5,0) is stalled in EMIT.
        push_pass(1'b1, 8, 2, 0, 5);
        b_ready = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_valid && b_lx == 8'd5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        b_ready = 1'b0;
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL B reach cell 5: got no record for (5,0), expected one within 200 cycles");
        end
        repeat (3) step();
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        chk("B post-reset busy", 32'(b_busy), 32'd0);
        chk("B post-reset valid", 32'(b_valid), 32'd0);
        chk("B post-reset done", 32'(b_done), 32'd0);
        chk("B post-reset data", 32'(b_data), 32'd0);
        chk("B post-reset last", 32'(b_last), 32'd0);
        chk("B post-reset lookup_X", 32'(b_lx), 32'd0);
        chk("B post-reset sugar_total", 32'(b_tot), 32'd0);
        chk("B post-reset signal_max", 32'(b_max), 32'd0);
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("B no done after reset", 32'(b_done), 32'd0);
        end
        chk("B reset queue drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
